// File: rtl/mc_ctrl_pkg.sv
// Shared state, opcode, ALUOp and mux encodings for the multi-cycle MIPS main control unit.
// Build option MC_CTRL_BGEZ_EN makes opcode 000001 (bgez) a legal branch.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StImmEx  = 4'd10,
        StImmWb  = 4'd11,
        StJump   = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBgez  = 6'b000001;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] FnJr    = 6'b001000;

    localparam logic [2:0] AluOpRtype = 3'b010;
    localparam logic [2:0] AluOpAdd   = 3'b110;
    localparam logic [2:0] AluOpSlti  = 3'b011;
    localparam logic [2:0] AluOpSub   = 3'b001;
    localparam logic [2:0] AluOpLui   = 3'b100;
    localparam logic [2:0] AluOpOri   = 3'b111;
    localparam logic [2:0] AluOpBgez  = 3'b101;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;
    localparam logic [1:0] PcSrcRs     = 2'b11;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] BrEq  = 2'b00;
    localparam logic [1:0] BrNe  = 2'b01;
    localparam logic [1:0] BrGez = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] branch_type;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    // State following DECODE; StFetch marks an unknown opcode.
    function automatic state_e decode_target(input logic [5:0] opcode);
        state_e nxt;
        case (opcode)
            OpRtype:                        nxt = StExec;
            OpLw, OpSw:                     nxt = StMemAdr;
            OpBeq, OpBne:                   nxt = StBranch;
            OpAddi, OpSlti, OpLui, OpOri:   nxt = StImmEx;
            OpJ:                            nxt = StJump;
`ifdef MC_CTRL_BGEZ_EN
            OpBgez:                         nxt = StBranch;
`endif
            default:                        nxt = StFetch;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit bus: IR fields and memory ready in, datapath control word, debug state and
// retired-instruction count out.
interface mc_ctrl_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode_i;
    logic [5:0]       funct_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic [1:0]       branch_type_o;
    logic [1:0]       pc_src_o;
    logic             i_or_d_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             ir_write_o;
    logic             reg_dst_o;
    logic             mem_to_reg_o;
    logic             reg_write_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic             zero_ext_o;
    logic [2:0]       alu_op_o;
    logic             illegal_o;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] instr_cnt_o;

    modport master (
        input  opcode_i, funct_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, branch_type_o, pc_src_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, zero_ext_o, alu_op_o, illegal_o, state_o, instr_cnt_o
    );

    modport slave (
        output opcode_i, funct_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, branch_type_o, pc_src_o, i_or_d_o, mem_read_o,
               mem_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, zero_ext_o, alu_op_o, illegal_o, state_o, instr_cnt_o
    );
endinterface

// File: rtl/mc_ctrl_out_dec.sv
// Combinational state/opcode -> control-word decoder; only FETCH enables depend on mem_ready_i.
// Build option MC_CTRL_BGEZ_EN selects the bgez branch encoding in BRANCH.
module mc_ctrl_out_dec
    import mc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluOpAdd;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            StDecode: begin
                ctrl_o.alu_src_b = SrcBImmSh;
                ctrl_o.alu_op    = AluOpAdd;
                ctrl_o.illegal   = (decode_target(opcode_i) == StFetch);
            end
            StMemAdr: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluOpAdd;
            end
            StMemRd: begin
                ctrl_o.i_or_d   = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            StMemWb: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            StMemWr: begin
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBReg;
                ctrl_o.alu_op    = AluOpRtype;
                if (funct_i == FnJr) begin
                    ctrl_o.pc_src   = PcSrcRs;
                    ctrl_o.pc_write = 1'b1;
                end
            end
            StAluWb: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SrcBReg;
                ctrl_o.alu_op        = AluOpSub;
                ctrl_o.pc_src        = PcSrcAluOut;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.branch_type   = (opcode_i == OpBne) ? BrNe : BrEq;
`ifdef MC_CTRL_BGEZ_EN
                if (opcode_i == OpBgez) begin
                    ctrl_o.alu_op      = AluOpBgez;
                    ctrl_o.branch_type = BrGez;
                end
`endif
            end
            StImmEx: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                case (opcode_i)
                    OpSlti:  ctrl_o.alu_op = AluOpSlti;
                    OpLui:   ctrl_o.alu_op = AluOpLui;
                    OpOri: begin
                        ctrl_o.alu_op   = AluOpOri;
                        ctrl_o.zero_ext = 1'b1;
                    end
                    default: ctrl_o.alu_op = AluOpAdd;
                endcase
            end
            StImmWb: ctrl_o.reg_write = 1'b1;
            StJump: begin
                ctrl_o.pc_src   = PcSrcJump;
                ctrl_o.pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM: sequences fetch..writeback, counts retired instructions.
// Build option MC_CTRL_BGEZ_EN enables the bgez opcode (decoded in mc_ctrl_pkg/out_dec).
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mc_ctrl_fsm_if.master bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire;
    ctrl_t            w_ctrl;

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            StIdle:   w_state_nxt = StFetch;
            StFetch:  if (bus.mem_ready_i) w_state_nxt = StDecode;
            StDecode: w_state_nxt = decode_target(bus.opcode_i);
            StMemAdr: w_state_nxt = (bus.opcode_i == OpSw) ? StMemWr : StMemRd;
            StMemRd:  if (bus.mem_ready_i) w_state_nxt = StMemWb;
            StMemWr: begin
                if (bus.mem_ready_i) begin
                    w_state_nxt = StFetch;
                    w_retire    = 1'b1;
                end
            end
            StExec: begin
                if (bus.funct_i == FnJr) begin
                    w_state_nxt = StFetch;
                    w_retire    = 1'b1;
                end else begin
                    w_state_nxt = StAluWb;
                end
            end
            StImmEx:  w_state_nxt = StImmWb;
            StMemWb, StAluWb, StBranch, StImmWb, StJump: begin
                w_state_nxt = StFetch;
                w_retire    = 1'b1;
            end
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    mc_ctrl_out_dec u_out_dec (
        .state_i     (r_state),
        .opcode_i    (bus.opcode_i),
        .funct_i     (bus.funct_i),
        .mem_ready_i (bus.mem_ready_i),
        .ctrl_o      (w_ctrl)
    );

    assign bus.pc_write_o      = w_ctrl.pc_write;
    assign bus.pc_write_cond_o = w_ctrl.pc_write_cond;
    assign bus.branch_type_o   = w_ctrl.branch_type;
    assign bus.pc_src_o        = w_ctrl.pc_src;
    assign bus.i_or_d_o        = w_ctrl.i_or_d;
    assign bus.mem_read_o      = w_ctrl.mem_read;
    assign bus.mem_write_o     = w_ctrl.mem_write;
    assign bus.ir_write_o      = w_ctrl.ir_write;
    assign bus.reg_dst_o       = w_ctrl.reg_dst;
    assign bus.mem_to_reg_o    = w_ctrl.mem_to_reg;
    assign bus.reg_write_o     = w_ctrl.reg_write;
    assign bus.alu_src_a_o     = w_ctrl.alu_src_a;
    assign bus.alu_src_b_o     = w_ctrl.alu_src_b;
    assign bus.zero_ext_o      = w_ctrl.zero_ext;
    assign bus.alu_op_o        = w_ctrl.alu_op;
    assign bus.illegal_o       = w_ctrl.illegal;
    assign bus.state_o         = r_state;
    assign bus.instr_cnt_o     = r_cnt;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle MIPS main control unit and the producer side of the ALUOp interface: decodes opcode/funct, sequences fetch/decode/execute/memory/writeback, and drives `alu_op_o[2:0]` to the downstream ALU controller.
- ALUOp encoding is fixed: 010 R-type, 110 add, 011 slti, 001 sub/branch, 100 lui, 111 ori, 101 bgez.
- Sits between the instruction register and the multi-cycle datapath muxes and enables.
- Memory is a single shared port with a ready handshake.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset (see Behaviour).
- opcode_i  in  6  IR[31:26].
- funct_i  in  6  IR[5:0].
- mem_ready_i  in  1  memory access completes this cycle.
- pc_write_o  out  1  unconditional PC write.
- pc_write_cond_o  out  1  PC write if branch condition is true.
- branch_type_o  out  2  00 beq, 01 bne, 10 bgez.
- pc_src_o  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 rs.
- i_or_d_o  out  1  0 PC address, 1 ALUOut address.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  IR load enable.
- reg_dst_o  out  1  0 rt, 1 rd.
- mem_to_reg_o  out  1  0 ALUOut, 1 MDR.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  1  0 PC, 1 A.
- alu_src_b_o  out  2  00 B, 01 const 4, 10 imm, 11 imm<<2.
- zero_ext_o  out  1  zero-extend immediate (ori).
- alu_op_o  out  3  ALUOp to the ALU controller.
- illegal_o  out  1  one-cycle pulse on an unknown opcode.
- state_o  out  4  current state, for debug.
- instr_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: clk_i is the single clock; rst_i is asynchronous, active-high.
  - In reset: state = IDLE, instr_cnt_o = 0.
  - IDLE decodes every output to 0.
  - IDLE -> FETCH on the first clock after rst_i deasserts.
  - rst_i asserted mid-instruction aborts immediately to IDLE. No memory or register writes are asserted afterwards.
- Output style: Moore outputs decoded from state and latched IR fields. The exceptions are the ready-qualified enables, which are combinational on mem_ready_i.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=110, pc_src=00.
  - ir_write and pc_write = mem_ready_i.
  - Stay in FETCH until mem_ready_i, then go to DECODE.
- DECODE:
  - Outputs: src_a=0, src_b=11, alu_op=110 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 -> EXEC
    - 100011 / 101011 -> MEMADR
    - 000100 / 000101 -> BRANCH
    - 001000 / 001010 / 001111 / 001101 -> IMMEX
    - 000010 -> JUMP
    - else: illegal_o=1, go to FETCH, not counted.
- MEMADR: src_a=1, src_b=10, alu_op=110. lw -> MEMRD, sw -> MEMWR.
- MEMRD: i_or_d=1, mem_read=1. Hold until mem_ready_i, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
- MEMWR: i_or_d=1, mem_write=1. Hold until mem_ready_i, then go to FETCH.
- EXEC: src_a=1, src_b=00, alu_op=010.
  - funct 001000 (jr): pc_src=11, pc_write=1, go to FETCH.
  - Otherwise go to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=001, pc_src=01, pc_write_cond=1. branch_type = 00 for beq, 01 for bne. Go to FETCH.
- IMMEX: src_a=1, src_b=10.
  - alu_op: addi 110, slti 011, lui 100, ori 111.
  - zero_ext=1 for ori only.
  - Go to IMMWB.
- IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH.
- JUMP: pc_src=10, pc_write=1. Go to FETCH.
- Instruction counter:
  - instr_cnt_o increments by 1 on each transition into FETCH from MEMWB, MEMWR (ready), ALUWB, EXEC (jr), BRANCH, IMMWB or JUMP.
  - Wraps modulo 2^CNT_W.
- Memory handshake: mem_ready_i is ignored outside FETCH, MEMRD and MEMWR. A ready arriving in the same cycle the state is entered completes that access in one cycle.
- IR stability: opcode_i and funct_i are sampled only in states after DECODE. The IR is stable there because ir_write is 0.

Optional Feature:
- Macro: MC_CTRL_BGEZ_EN.
- Defined: opcode 000001 goes DECODE -> BRANCH with alu_op=101 and branch_type=10.
- Undefined: opcode 000001 is illegal (illegal_o pulse, return to FETCH).

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings (IDLE..JUMP, 4-bit);
  - opcode constants;
  - ALUOp constants (matching the encoding above);
  - pc_src and alu_src_b encodings.
- Natural sub-module: mc_ctrl_out_dec, the combinational state/opcode -> control-word decoder. Next-state logic and the counter stay in mc_ctrl_fsm.

Test Plan:
1. Reset then release, mem_ready_i=1 -> IDLE 1 cycle with all outputs 0; FETCH with mem_read=1, ir_write=1, pc_write=1, alu_op=110.
2. Opcode 000000, funct 100000, ready=1 -> FETCH, DECODE, EXEC (alu_op=010), ALUWB (reg_write=1, reg_dst=1); instr_cnt_o=1.
3. lw with mem_ready_i low 3 cycles in MEMRD -> mem_read held 4 cycles; then MEMWB mem_to_reg=1; 5 states + 3 waits total.
4. bne (000101) -> BRANCH alu_op=001, branch_type=01, pc_write_cond=1; ori (001101) -> IMMEX alu_op=111, zero_ext=1.
5. Opcode 111111 -> illegal_o pulse in DECODE, return to FETCH, count unchanged. Opcode 000001 behaves per the MC_CTRL_BGEZ_EN setting.
6. rst_i asserted during MEMWR -> state_o=IDLE asynchronously, mem_write_o drops same cycle, counter=0.
